// File: rtl/brick_pkg.sv
// Shared types and helpers for the falling-brick gravity engine.
// Optional feature macro: BRICK_SCORE_EN (cleared-row score counter).
package brick_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FALL  = 3'd1,
        LAND  = 3'd2,
        CLEAR = 3'd3,
        LOST  = 3'd4
    } state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Stack colour for a column; cycles through three colours.
    function automatic logic [4:0] col_color(input int c);
        logic [4:0] color;
        case (c % 3)
            0:       color = 5'b00001;
            1:       color = 5'b00100;
            default: color = 5'b10000;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/brick_renderer.sv
// Maps the current scan position onto the column/slot grid and registers the
// resulting pixel colour (one clock of latency). The falling brick is drawn
// over the stack.
module brick_renderer
    import brick_pkg::*;
#(
    parameter int NUM_COLS            = 3,
    parameter int MAX_HEIGHT          = 5,
    parameter int COL_W               = 3,
    parameter int ROW_W               = 3,
    parameter int X_MARGIN            = 5,
    parameter int BRICK_W             = 210,
    parameter int BRICK_H             = 80,
    parameter logic [4:0] FALL_COLOR  = 5'b11111
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_COLS*ROW_W-1:0]  heights,
    input  logic [ROW_W-1:0]           row,
    input  logic [COL_W-1:0]           col,
    input  logic                       falling,
    input  logic [10:0]                hpos,
    input  logic [10:0]                vpos,
    output logic [4:0]                 pixel_color
);

    localparam logic [ROW_W:0] MAX_H_EXT = (ROW_W+1)'(MAX_HEIGHT);

    int               scan_x;
    int               scan_y;
    logic             hit_x;
    logic             hit_y;
    logic             on_screen;
    logic [COL_W-1:0] cell_col;
    logic [ROW_W-1:0] cell_row;
    logic [ROW_W-1:0] cell_h;
    logic [4:0]       cell_color;
    logic [4:0]       color_next;

    // Locate the cell under the scan position and pick its colour.
    always_comb begin
        scan_x     = int'(hpos);
        scan_y     = int'(vpos);
        on_screen  = (scan_x < SCREEN_W) && (scan_y < SCREEN_H);
        hit_x      = 1'b0;
        hit_y      = 1'b0;
        cell_col   = '0;
        cell_row   = '0;
        cell_h     = '0;
        cell_color = 5'b00000;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (scan_x >= X_MARGIN + c*BRICK_W && scan_x < X_MARGIN + (c+1)*BRICK_W) begin
                hit_x      = 1'b1;
                cell_col   = COL_W'(c);
                cell_h     = heights[c*ROW_W +: ROW_W];
                cell_color = col_color(c);
            end
        end
        for (int r = 0; r < MAX_HEIGHT; r++) begin
            if (scan_y >= r*BRICK_H && scan_y < (r+1)*BRICK_H) begin
                hit_y    = 1'b1;
                cell_row = ROW_W'(r);
            end
        end
        color_next = 5'b00000;
        if (on_screen && hit_x && hit_y) begin
            if (falling && cell_col == col && cell_row == row) begin
                color_next = FALL_COLOR;
            end else if (({1'b0, cell_row} + {1'b0, cell_h}) >= MAX_H_EXT) begin
                color_next = cell_color;
            end
        end
    end

    // Output register for the VGA path.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_color <= 5'b00000;
        end else begin
            pixel_color <= color_next;
        end
    end

endmodule

// File: rtl/brick_gravity.sv
// Gravity/stacking engine: per-column stack heights, falling brick position,
// lateral moves, landing, full-bottom-row clear and sticky game-over.
// Optional feature macro: BRICK_SCORE_EN builds the cleared-row counter;
// without it score reads 0.
//
// state | meaning
// IDLE  | waiting for a spawn request
// FALL  | brick in flight, moves and ticks applied
// LAND  | brick just joined its stack, check for a full bottom row
// CLEAR | bottom row removed this cycle
// LOST  | spawn into a full column, held until reset
module brick_gravity
    import brick_pkg::*;
#(
    parameter int NUM_COLS            = 3,
    parameter int MAX_HEIGHT          = 5,
    parameter int COL_W               = 3,
    parameter int ROW_W               = 3,
    parameter int X_MARGIN            = 5,
    parameter int BRICK_W             = 210,
    parameter int BRICK_H             = 80,
    parameter logic [4:0] FALL_COLOR  = 5'b11111
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       spawn_valid,
    input  logic [COL_W-1:0]           spawn_col,
    output logic                       spawn_ready,
    input  logic                       move_left,
    input  logic                       move_right,
    input  logic [10:0]                hpos,
    input  logic [10:0]                vpos,
    output logic [NUM_COLS*ROW_W-1:0]  heights,
    output logic [ROW_W-1:0]           row,
    output logic [COL_W-1:0]           col,
    output logic                       falling,
    output logic                       landed,
    output logic                       cleared,
    output logic                       lost,
    output logic [7:0]                 score,
    output logic [4:0]                 pixel_color
);

    localparam logic [ROW_W:0] MAX_H_EXT = (ROW_W+1)'(MAX_HEIGHT);

    state_t                     state;
    logic [NUM_COLS*ROW_W-1:0]  heights_q;
    logic [NUM_COLS*ROW_W-1:0]  heights_inc;
    logic [NUM_COLS*ROW_W-1:0]  heights_dec;
    logic [ROW_W-1:0]           row_q;
    logic [COL_W-1:0]           col_q;
    logic                       landed_q;
    logic                       cleared_q;
    logic                       spawn_in_range;
    logic                       spawn_full;
    logic                       move_req;
    logic [COL_W-1:0]           move_col;
    logic [COL_W-1:0]           fall_col;
    logic                       at_floor;
    logic                       all_filled;

    // Out-of-range indices simply never match, so they read as height 0.
    function automatic logic [ROW_W-1:0] height_of(input logic [NUM_COLS*ROW_W-1:0] hv,
                                                   input logic [COL_W-1:0] idx);
        logic [ROW_W-1:0] h;
        h = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (idx == COL_W'(c)) h = hv[c*ROW_W +: ROW_W];
        end
        return h;
    endfunction

    // Spawn checks, move legality, landing test and next stack heights.
    always_comb begin
        spawn_in_range = int'(spawn_col) < NUM_COLS;
        spawn_full     = height_of(heights_q, spawn_col) == ROW_W'(MAX_HEIGHT);

        move_req = 1'b0;
        move_col = col_q;
        if (move_left && !move_right && col_q != '0) begin
            move_req = 1'b1;
            move_col = col_q - COL_W'(1);
        end else if (move_right && !move_left && int'(col_q) < NUM_COLS - 1) begin
            move_req = 1'b1;
            move_col = col_q + COL_W'(1);
        end

        // The brick may only slide beside a stack whose top is still below it.
        fall_col = col_q;
        if (move_req && ({1'b0, row_q} + {1'b0, height_of(heights_q, move_col)}) < MAX_H_EXT) begin
            fall_col = move_col;
        end

        at_floor = ({1'b0, row_q} + {1'b0, height_of(heights_q, fall_col)} + (ROW_W+1)'(1))
                   == MAX_H_EXT;

        heights_inc = heights_q;
        heights_dec = heights_q;
        all_filled  = 1'b1;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (heights_q[c*ROW_W +: ROW_W] == '0) all_filled = 1'b0;
            heights_dec[c*ROW_W +: ROW_W] = heights_q[c*ROW_W +: ROW_W] - ROW_W'(1);
            if (fall_col == COL_W'(c)) begin
                heights_inc[c*ROW_W +: ROW_W] = heights_q[c*ROW_W +: ROW_W] + ROW_W'(1);
            end
        end
    end

    // Game FSM; landed/cleared are registered so they coincide with the
    // updated heights. The clear is committed on entry to CLEAR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            heights_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            landed_q  <= 1'b0;
            cleared_q <= 1'b0;
        end else begin
            landed_q  <= 1'b0;
            cleared_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (spawn_valid && spawn_in_range) begin
                        if (spawn_full) begin
                            state <= LOST;
                        end else begin
                            col_q <= spawn_col;
                            row_q <= '0;
                            state <= FALL;
                        end
                    end
                end
                FALL: begin
                    col_q <= fall_col;
                    if (tick) begin
                        if (at_floor) begin
                            heights_q <= heights_inc;
                            landed_q  <= 1'b1;
                            state     <= LAND;
                        end else begin
                            row_q <= row_q + ROW_W'(1);
                        end
                    end
                end
                LAND: begin
                    if (all_filled) begin
                        heights_q <= heights_dec;
                        cleared_q <= 1'b1;
                        state     <= CLEAR;
                    end else begin
                        state <= IDLE;
                    end
                end
                CLEAR: state <= IDLE;
                LOST:  state <= LOST;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRICK_SCORE_EN
    logic [7:0] score_q;

    // Count bottom-row clears, holding at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= 8'd0;
        end else if (state == LAND && all_filled && score_q != 8'hFF) begin
            score_q <= score_q + 8'd1;
        end
    end

    assign score = score_q;
`else
    assign score = 8'd0;
`endif

    assign heights     = heights_q;
    assign row         = row_q;
    assign col         = col_q;
    assign landed      = landed_q;
    assign cleared     = cleared_q;
    assign falling     = (state == FALL);
    assign lost        = (state == LOST);
    assign spawn_ready = (state == IDLE);

    brick_renderer #(
        .NUM_COLS   (NUM_COLS),
        .MAX_HEIGHT (MAX_HEIGHT),
        .COL_W      (COL_W),
        .ROW_W      (ROW_W),
        .X_MARGIN   (X_MARGIN),
        .BRICK_W    (BRICK_W),
        .BRICK_H    (BRICK_H),
        .FALL_COLOR (FALL_COLOR)
    ) u_renderer (
        .clk         (clk),
        .reset       (reset),
        .heights     (heights_q),
        .row         (row_q),
        .col         (col_q),
        .falling     (falling),
        .hpos        (hpos),
        .vpos        (vpos),
        .pixel_color (pixel_color)
    );

endmodule

// File: doc/brick_gravity.md
Name: brick_gravity

Overview:
- Parametrised gravity/stacking engine for the falling-brick game, generalising the fixed three-column version to NUM_COLS columns and MAX_HEIGHT rows.
- Owns the per-column stack heights, the falling brick's row and column, lateral moves, landing, bottom-row clear and game-over.
- Drives a registered pixel colour for the VGA scan path.

Parameters:
- NUM_COLS, 3, number of columns (2..8).
- MAX_HEIGHT, 5, rows per column; stack full at MAX_HEIGHT.
- COL_W, 3, width of column index (clog2 of NUM_COLS, min 1).
- ROW_W, 3, width of row/height values (holds 0..MAX_HEIGHT).
- X_MARGIN, 5, left pixel offset of column 0.
- BRICK_W, 210, brick width in pixels.
- BRICK_H, 80, brick height in pixels.
- FALL_COLOR, 5'b11111, colour of the falling brick.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- tick  in  1  gravity pulse, one cycle wide
- spawn_valid  in  1  request new brick
- spawn_col  in  COL_W  column of new brick
- spawn_ready  out  1  high only in IDLE
- move_left  in  1  shift falling brick one column left
- move_right  in  1  shift falling brick one column right
- hpos  in  11  scan x
- vpos  in  11  scan y
- heights  out  NUM_COLS*ROW_W  packed stack heights, column 0 in LSBs
- row  out  ROW_W  falling brick row, 0 = top
- col  out  COL_W  falling brick column
- falling  out  1  brick in flight
- landed  out  1  one-cycle pulse on landing
- cleared  out  1  one-cycle pulse on bottom-row clear
- lost  out  1  sticky game-over
- score  out  8  cleared-row count (see Optional Feature)
- pixel_color  out  5  registered pixel colour

Behaviour:
- Reset (synchronous, active-high; wins over all inputs): state IDLE; heights, row, col, score, pixel_color all 0; landed, cleared, lost, falling all 0.
- States: IDLE, FALL, LAND, CLEAR, LOST.
- IDLE, spawn_ready=1:
  - spawn_valid with spawn_col >= NUM_COLS: ignored.
  - Else if heights[spawn_col]==MAX_HEIGHT: go to LOST.
  - Else: col<=spawn_col, row<=0, go to FALL.
- FALL, falling=1:
  - Moves first: a move is applied only when the target column exists and row < MAX_HEIGHT - heights[target].
  - move_left and move_right together: both ignored.
  - Tick is then evaluated on the updated col. If row == MAX_HEIGHT-1-heights[col], the brick lands: heights[col]++, landed pulse, go to LAND. Otherwise row++.
  - A tick and a move in the same cycle both take effect.
- LAND, one cycle:
  - If every height is >= 1: go to CLEAR.
  - Else: go to IDLE.
- CLEAR, one cycle: every height decrements by 1, cleared pulse, score+1 saturating at 255, go to IDLE.
- LOST: lost=1 and falling=0; spawn and move inputs ignored; exit only via reset.
- Arithmetic: row + height compares are done at ROW_W+1 bits, with no wrap.
- Rendering, latency 1 clk (pixel_color is registered from the current hpos/vpos):
  - Column c spans x in [X_MARGIN+c*BRICK_W, X_MARGIN+(c+1)*BRICK_W).
  - Slot r spans y in [r*BRICK_H, (r+1)*BRICK_H).
  - Stack cells are slots r >= MAX_HEIGHT-heights[c], coloured col_color(c).
  - The falling brick cell (row, col) uses FALL_COLOR and overrides the stack.
  - Everything else is 0.
- Reset mid-fall or mid-clear discards all state, with no landed or cleared pulse.

Optional Feature:
- Macro BRICK_SCORE_EN.
- Defined: score counts clears as specified.
- Undefined: score is tied to 8'd0 and the counter is not built; port list unchanged.

Decomposition:
- Package brick_pkg:
  - state enum (IDLE, FALL, LAND, CLEAR, LOST);
  - screen constants (640x480);
  - function col_color(c) returning 5-bit colours 5'b00001, 5'b00100, 5'b10000, repeating modulo 3.
- One sub-module brick_renderer: pure pixel mapping plus output register.
  - Inputs: heights, row, col, falling, hpos, vpos.
  - Output: pixel_color.

Test Plan:
- Reset, spawn col 1, 5 ticks: row 0→4; landed on the 5th tick; heights={0,1,0}; state back to IDLE after LAND.
- heights {2,0,0}, brick in col 1 at row 3, move_left: refused (3 >= 5-2); at row 2 move_left is accepted and col=0.
- Fill cols 0 and 2 to 1, land in col 1: one cycle after landed, cleared pulses; heights={0,0,0}; score=1 with BRICK_SCORE_EN.
- Col 0 at height 5, spawn_col 0: lost=1 next cycle, stays 1 through 10 spawns; clears only on reset.
- Brick at row 1 col 2: hpos=5+2*210+10, vpos=90 → pixel_color=5'b11111 one clk later; background pixel → 0.
- Reset asserted together with a landing tick: heights unchanged at 0, landed=0, state IDLE.
